// File: rtl/axi_tb_pkg.sv
// Shared types for the AXI3 write responder: response codes, FIFO entry layouts, B FSM states.
// Entry field widths must match the responder's AXI_ADDR_W / AXI_ID_W parameters.
package axi_tb_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam int PKG_ID_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [PKG_ID_W-1:0]   id;
    logic [3:0]            len;
    logic [PKG_ADDR_W-1:0] addr;
  } aw_entry_t;

  typedef struct packed {
    logic [PKG_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_entry_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_WAIT,
    B_RESP
  } b_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO; head is combinational from storage, so a push is visible next cycle.
// DEPTH must be a power of 2 (>= 2); push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_slv_wr_responder.sv
// AXI3 write slave: AW FIFO, in-order W checking, one B per burst after B_LATENCY idle cycles.
// Optional SLV_WR_RANDOM_BACKPRESSURE_EN gates AW/W ready with a free-running LFSR.
module axi_slv_wr_responder
  import axi_tb_pkg::*;
#(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_ID_W        = 4,
  parameter int AXI_DATA_W      = 32,
  parameter int SLV_OSTDREQ_NUM = 4,
  parameter int B_LATENCY       = 2
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               srst,
  input  logic                               in_awvalid,
  output logic                               out_awready,
  input  logic [AXI_ADDR_W-1:0]              in_awaddr,
  input  logic [3:0]                         in_awlen,
  input  logic [2:0]                         in_awsize,
  input  logic [1:0]                         in_awburst,
  input  logic [AXI_ID_W-1:0]                in_awid,
  input  logic [1:0]                         in_awlock,
  input  logic                               in_wvalid,
  output logic                               out_wready,
  input  logic                               in_wlast,
  input  logic [AXI_ID_W-1:0]                in_wid,
  input  logic [AXI_DATA_W-1:0]              in_wdata,
  input  logic [AXI_DATA_W/8-1:0]            in_wstrb,
  output logic                               out_bvalid,
  input  logic                               in_bready,
  output logic [AXI_ID_W-1:0]                out_bid,
  output logic [1:0]                         out_bresp,
  output logic                               out_err_pulse,
  output logic [$clog2(SLV_OSTDREQ_NUM):0]   out_ostd_cnt
);

  localparam logic [3:0] B_LAT4 = B_LATENCY[3:0];

  logic      rst_done;
  aw_entry_t aw_push_dat, aw_head;
  b_entry_t  b_push_dat, b_head;
  logic      aw_full, aw_empty, b_full, b_empty;
  logic [$clog2(SLV_OSTDREQ_NUM):0] b_cnt;
  logic      aw_hs, w_hs, b_pop;
  logic      burst_last, beat_err, burst_done;
  logic [1:0] burst_resp;
  logic [3:0] beat_cnt;
  logic      err_flag;
  b_state_t  b_state, b_nxt;
  logic [3:0] dly_cnt, dly_nxt;
  logic      unused_bits;

`ifdef SLV_WR_RANDOM_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  lfsr <= 16'hACE1;
    else if (srst) lfsr <= 16'hACE1;
    else           lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign out_awready = rst_done && !aw_full && lfsr[0];
  assign out_wready  = !aw_empty && !b_full && lfsr[1];
`else
  assign out_awready = rst_done && !aw_full;
  assign out_wready  = !aw_empty && !b_full;
`endif

  assign aw_hs = in_awvalid && out_awready;
  assign w_hs  = in_wvalid && out_wready;

  assign aw_push_dat.id   = in_awid;
  assign aw_push_dat.len  = in_awlen;
  assign aw_push_dat.addr = in_awaddr;

  // Completion is decided by the beat count alone; a wrong WLAST only marks the burst bad.
  assign burst_last = (beat_cnt == aw_head.len);
  assign beat_err   = (in_wid != aw_head.id) || (in_wlast != burst_last);
  assign burst_done = w_hs && burst_last;
  assign burst_resp = (err_flag || beat_err) ? RESP_SLVERR : RESP_OKAY;

  assign b_push_dat.id   = aw_head.id;
  assign b_push_dat.resp = burst_resp;

  sync_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_aw_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .clr      (srst),
    .push     (aw_hs),
    .push_dat (aw_push_dat),
    .pop      (burst_done),
    .head_dat (aw_head),
    .full     (aw_full),
    .empty    (aw_empty),
    .count    (out_ostd_cnt)
  );

  sync_fifo #(.WIDTH($bits(b_entry_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_b_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .clr      (srst),
    .push     (burst_done),
    .push_dat (b_push_dat),
    .pop      (b_pop),
    .head_dat (b_head),
    .full     (b_full),
    .empty    (b_empty),
    .count    (b_cnt)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done      <= 1'b0;
      beat_cnt      <= '0;
      err_flag      <= 1'b0;
      out_err_pulse <= 1'b0;
    end else if (srst) begin
      rst_done      <= 1'b0;
      beat_cnt      <= '0;
      err_flag      <= 1'b0;
      out_err_pulse <= 1'b0;
    end else begin
      rst_done      <= 1'b1;
      out_err_pulse <= burst_done && (burst_resp == RESP_SLVERR);
      if (burst_done) begin
        beat_cnt <= '0;
        err_flag <= 1'b0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 4'd1;
        err_flag <= err_flag || beat_err;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      b_state <= B_IDLE;
      dly_cnt <= '0;
    end else if (srst) begin
      b_state <= B_IDLE;
      dly_cnt <= '0;
    end else begin
      b_state <= b_nxt;
      dly_cnt <= dly_nxt;
    end
  end

  // The IDLE cycle itself counts as one latency cycle, so WAIT leaves at count 2.
  always_comb begin
    b_nxt   = b_state;
    dly_nxt = dly_cnt;
    case (b_state)
      B_IDLE: begin
        if (!b_empty) begin
          if (B_LATENCY <= 1) begin
            b_nxt = B_RESP;
          end else begin
            b_nxt   = B_WAIT;
            dly_nxt = B_LAT4;
          end
        end
      end
      B_WAIT: begin
        dly_nxt = dly_cnt - 4'd1;
        if (dly_cnt <= 4'd2) b_nxt = B_RESP;
      end
      B_RESP: begin
        if (in_bready) b_nxt = B_IDLE;
      end
      default: b_nxt = B_IDLE;
    endcase
  end

  assign out_bvalid = (b_state == B_RESP);
  assign b_pop      = out_bvalid && in_bready;
  assign out_bid    = out_bvalid ? b_head.id : '0;
  assign out_bresp  = out_bvalid ? b_head.resp : RESP_OKAY;

  assign unused_bits = ^{in_awsize, in_awburst, in_awlock, in_wdata, in_wstrb, aw_head.addr, b_cnt};

endmodule

// File: tb/tb_axi_slv_wr_responder.sv
// Directed scenarios plus randomized traffic, all checked every cycle against a queue-based model.
module tb_axi_slv_wr_responder;

  localparam int ID_W  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              srst = 1'b0;
  logic              in_awvalid = 1'b0;
  logic              out_awready;
  logic [ADDR_W-1:0] in_awaddr = '0;
  logic [3:0]        in_awlen = '0;
  logic [2:0]        in_awsize = 3'd2;
  logic [1:0]        in_awburst = 2'd1;
  logic [ID_W-1:0]   in_awid = '0;
  logic [1:0]        in_awlock = 2'd0;
  logic              in_wvalid = 1'b0;
  logic              out_wready;
  logic              in_wlast = 1'b0;
  logic [ID_W-1:0]   in_wid = '0;
  logic [DATA_W-1:0] in_wdata = '0;
  logic [DATA_W/8-1:0] in_wstrb = '0;
  logic              out_bvalid;
  logic              in_bready = 1'b1;
  logic [ID_W-1:0]   out_bid;
  logic [1:0]        out_bresp;
  logic              out_err_pulse;
  logic [2:0]        out_ostd_cnt;

  always #5 aclk = ~aclk;

  axi_slv_wr_responder #(
    .AXI_ADDR_W(ADDR_W), .AXI_ID_W(ID_W), .AXI_DATA_W(DATA_W),
    .SLV_OSTDREQ_NUM(DEPTH), .B_LATENCY(LAT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .in_awvalid(in_awvalid), .out_awready(out_awready), .in_awaddr(in_awaddr),
    .in_awlen(in_awlen), .in_awsize(in_awsize), .in_awburst(in_awburst),
    .in_awid(in_awid), .in_awlock(in_awlock),
    .in_wvalid(in_wvalid), .out_wready(out_wready), .in_wlast(in_wlast),
    .in_wid(in_wid), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
    .out_bvalid(out_bvalid), .in_bready(in_bready), .out_bid(out_bid),
    .out_bresp(out_bresp), .out_err_pulse(out_err_pulse), .out_ostd_cnt(out_ostd_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: outstanding bursts, pending responses, and when each response may appear.
  typedef struct { logic [3:0] id; int len; } aw_m_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; int pushed; } b_m_t;
  aw_m_t awq[$];
  b_m_t  bq[$];
  bit m_rst_done;
  int m_beats;
  bit m_bad;
  bit m_err_pulse;
  int m_last_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    awq.delete();
    bq.delete();
    m_rst_done = 0;
    m_beats = 0;
    m_bad = 0;
    m_err_pulse = 0;
    m_last_b = 0;
  endtask

  function automatic bit m_awready();
    return m_rst_done && (awq.size() < DEPTH);
  endfunction

  function automatic bit m_wready();
    return (awq.size() > 0) && (bq.size() < DEPTH);
  endfunction

  // A response is shown LAT cycles after it is both queued and at the head (at least 1).
  function automatic bit m_bvalid();
    int start;
    if (bq.size() == 0) return 1'b0;
    start = (bq[0].pushed > m_last_b) ? bq[0].pushed : m_last_b;
    return cyc >= start + ((LAT < 2) ? 1 : LAT);
  endfunction

  task automatic compare();
    chk("awready", out_awready, m_awready());
    chk("wready", out_wready, m_wready());
    chk("bvalid", out_bvalid, m_bvalid());
    chk("ostd_cnt", out_ostd_cnt, awq.size());
    chk("err_pulse", out_err_pulse, m_err_pulse);
    if (m_bvalid()) begin
      chk("bid", out_bid, bq[0].id);
      chk("bresp", out_bresp, bq[0].resp);
    end
  endtask

  task automatic model_step();
    int e;
    bit aw_hs, w_hs, b_hs, last;
    e = cyc + 1;
    aw_hs = in_awvalid && m_awready();
    w_hs  = in_wvalid && m_wready();
    b_hs  = in_bready && m_bvalid();
    m_err_pulse = 0;
    if (!aresetn || srst) begin
      model_reset();
      return;
    end
    if (w_hs) begin
      last = (m_beats == awq[0].len);
      if (in_wid != awq[0].id || in_wlast != last) m_bad = 1;
      if (last) begin
        bq.push_back('{awq[0].id, m_bad ? 2'b10 : 2'b00, e});
        m_err_pulse = m_bad;
        void'(awq.pop_front());
        m_beats = 0;
        m_bad = 0;
      end else begin
        m_beats++;
      end
    end
    if (b_hs) begin
      void'(bq.pop_front());
      m_last_b = e;
    end
    if (aw_hs) awq.push_back('{in_awid, int'(in_awlen)});
    m_rst_done = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
    compare();
  endtask

  task automatic idle(input bit bready);
    in_awvalid = 0;
    in_wvalid = 0;
    in_wlast = 0;
    in_bready = bready;
  endtask

  task automatic drive_aw(input logic [3:0] id, input logic [3:0] len);
    in_awvalid = 1;
    in_awid = id;
    in_awlen = len;
    in_awaddr = $urandom;
  endtask

  task automatic drive_w(input logic [3:0] id, input bit last);
    in_wvalid = 1;
    in_wid = id;
    in_wlast = last;
    in_wdata = $urandom;
    in_wstrb = 4'($urandom);
  endtask

  task automatic wait_b(input logic [3:0] id, input logic [1:0] resp, input string name);
    bit found = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_bvalid && out_bid == id) begin
        found = 1;
        break;
      end
      tick();
    end
    if (found) begin
      chk(name, out_bresp, resp);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: no B with bid %0h within 30 cycles", name, id);
    end
  endtask

  initial begin
    int seen;
    model_reset();
    @(negedge aclk);
    chk("rst_awready", out_awready, 0);
    chk("rst_bvalid", out_bvalid, 0);
    chk("rst_ostd", out_ostd_cnt, 0);
    tick();
    aresetn = 1;
    tick();

    // Single 4-beat burst; B three cycles after the last W handshake.
    idle(1); drive_aw(4'b0101, 4'd3); tick(); idle(1);
    for (int i = 0; i < 4; i++) begin drive_w(4'b0101, i == 3); tick(); end
    idle(1);
    chk("d1_bvalid_c1", out_bvalid, 0);
    tick(); chk("d1_bvalid_c2", out_bvalid, 0);
    tick(); chk("d1_bvalid_c3", out_bvalid, 1);
    chk("d1_bid", out_bid, 4'b0101);
    chk("d1_bresp", out_bresp, 2'b00);
    tick(); chk("d1_bvalid_after", out_bvalid, 0);

    // Fill the AW FIFO with W stalled.
    drive_aw(4'd1, 4'd0); tick();
    drive_aw(4'd2, 4'd1); tick();
    drive_aw(4'd5, 4'd0); tick();
    drive_aw(4'd6, 4'd0); tick();
    idle(1);
    chk("d2_awready_full", out_awready, 0);
    chk("d2_ostd_full", out_ostd_cnt, 4);
    drive_w(4'd1, 1); tick(); idle(1);
    chk("d2_awready_back", out_awready, 1);
    chk("d2_ostd_after", out_ostd_cnt, 3);

    // awlen=1 with early WLAST: completes after two beats with SLVERR.
    drive_w(4'd2, 1); tick();
    drive_w(4'd2, 1); tick(); idle(1);
    chk("d3_err_pulse", out_err_pulse, 1);
    tick(); chk("d3_err_pulse_end", out_err_pulse, 0);
    wait_b(4'd2, 2'b10, "d3_bresp");

    // Wrong WID against head awid 0101.
    drive_w(4'b0110, 1); tick(); idle(1);
    wait_b(4'b0101, 2'b10, "d4_bresp");
    drive_w(4'd6, 1); tick(); idle(1);
    wait_b(4'd6, 2'b00, "d4_ok_bresp");
    repeat (6) tick();

    // B held off: FIFO fills, W stalls, B stays stable.
    idle(0);
    for (int i = 0; i < 4; i++) begin drive_aw(4'(i + 8), 4'd0); tick(); end
    idle(0);
    for (int i = 0; i < 4; i++) begin drive_w(4'(i + 8), 1); tick(); end
    idle(0); drive_aw(4'd12, 4'd0); tick(); idle(0);
    chk("d5_wready_bfull", out_wready, 0);
    chk("d5_ostd", out_ostd_cnt, 1);
    for (int i = 0; i < 10; i++) begin
      chk("d5_bvalid_hold", out_bvalid, 1);
      chk("d5_bid_hold", out_bid, 4'd8);
      chk("d5_bresp_hold", out_bresp, 2'b00);
      tick();
    end
    idle(1);
    repeat (14) tick();
    drive_w(4'd12, 1); tick(); idle(1);
    repeat (6) tick();

    // Async reset in the middle of a burst.
    drive_aw(4'd9, 4'd3); tick(); idle(1);
    drive_w(4'd9, 0); tick();
    drive_w(4'd9, 0); tick();
    idle(1);
    aresetn = 0;
    #1;
    model_reset();
    chk("d6_awready", out_awready, 0);
    chk("d6_wready", out_wready, 0);
    chk("d6_bvalid", out_bvalid, 0);
    chk("d6_bid", out_bid, 0);
    chk("d6_bresp", out_bresp, 0);
    chk("d6_err_pulse", out_err_pulse, 0);
    chk("d6_ostd", out_ostd_cnt, 0);
    tick(); tick();
    aresetn = 1;
    chk("d6_awready_rel", out_awready, 0);
    tick();
    chk("d6_awready_2nd", out_awready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive_w(4'd9, i == 1);
      tick();
      if (out_bvalid) seen++;
    end
    idle(1);
    chk("d6_no_b", seen, 0);

    // Randomized traffic with occasional protocol errors and sync resets.
    for (int n = 0; n < 3000; n++) begin
      bit exp_last;
      in_awvalid = ($urandom_range(0, 99) < 40);
      in_awid = 4'($urandom);
      in_awlen = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      in_awaddr = $urandom;
      in_wvalid = ($urandom_range(0, 99) < 60);
      if (awq.size() > 0) begin
        exp_last = (m_beats == awq[0].len);
        in_wid = ($urandom_range(0, 19) == 0) ? 4'($urandom) : awq[0].id;
        in_wlast = ($urandom_range(0, 19) == 0) ? !exp_last : exp_last;
      end else begin
        in_wid = 4'($urandom);
        in_wlast = 1'($urandom);
      end
      in_wdata = $urandom;
      in_wstrb = 4'($urandom);
      in_bready = ($urandom_range(0, 99) < 70);
      srst = ($urandom_range(0, 499) == 0);
      tick();
    end
    srst = 0;
    idle(1);
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
